multislope_timing_core: RTL and testbench
=========================================

// Module: multislope_timing_core
// PURPOSE
//   Timing core of the multi-slope ADC: one clock domain generating a 100 kHz reference, a 1 ms timebase,
//   the conversion sequence (start / zero / runup) and the run-up PWM. Two cascaded toggle dividers, a
//   sequence FSM on 1 ms ticks, a PWM counter re-aligned on every 100 kHz tick. Feeds the analog switch drivers.
// PARAMETERS
//   DIV1      124  divider-1 terminal count; clk100k toggles every DIV1+1 clk cycles (25 MHz -> 100 kHz)
//   DIV2      49   divider-2 terminal count; ms toggles every DIV2+1 100 kHz ticks (-> 1 kHz)
//   PERIOD    249  PWM counter terminal count; PWM period = PERIOD+1 clk cycles
//   HI_M1     187  PWM high time (clk cycles) when mode=1
//   HI_M0     62   PWM high time (clk cycles) when mode=0
//   MS_PER_PL 20   ms per power-line cycle
// PORTS
//   clk      in   1   system clock (25 MHz nominal)
//   rst      in   1   asynchronous, active-high reset
//   npl      in   10  integration length in power-line cycles; 0 treated as 1
//   mode     in   1   PWM pattern select (sampled on each 100 kHz tick)
//   clk100k  out  1   100 kHz square wave (registered)
//   ms       out  1   1 kHz square wave (registered)
//   start    out  1   high during 1 ms START phase; also clears PWM
//   zero     out  1   high during ZERO (auto-zero) phase
//   runup    out  1   high during RUNUP phase; enables PWM
//   pwm      out  1   run-up PWM drive
// BEHAVIOUR
//   Reset: all counters 0; clk100k=ms=pwm=zero=runup=0; start=0; FSM=IDLE.
//   Divider 1: cnt1 0..DIV1; at cnt1==DIV1 -> cnt1=0, clk100k toggles. tick100k = 1-cycle strobe on clk100k 0->1
//     (every 250 clk; first at clk edge 125 after reset release is the 0->1... i.e. first toggle at edge 125).
//   Divider 2: advances only on tick100k; cnt2 0..DIV2, toggles ms at DIV2. tick1ms = strobe on ms 0->1
//     (every 25000 clk). Divider widths: ceil(log2(DIV+1)).
//   FSM, advances only on tick1ms; L = MS_PER_PL*max(npl,1) ms, npl sampled on entering START:
//     IDLE  -> START on first tick1ms.
//     START (start=1) 1 ms -> ZERO.
//     ZERO  (zero=1) L ms -> RUNUP.
//     RUNUP (runup=1) L ms -> START (free-running, repeats forever).
//     Exactly one of start/zero/runup high outside IDLE; outputs registered, change in the cycle after tick1ms.
//     Phase counter >= 15 bits (max 20460 ms).
//   PWM: pcnt 0..PERIOD, wraps to 0; on tick100k pcnt forced to 0 and mode latched into mode_q.
//     pwm = runup & (pcnt < (mode_q ? HI_M1 : HI_M0)), registered (1 clk latency).
//     start=1 holds pcnt=0, pwm=0 (synchronous clear). runup=0 -> pwm=0 while counter keeps running.
//     tick100k coinciding with pcnt==PERIOD: result 0 (same as wrap). Mode change mid-period takes effect next tick100k.
//   rst asserted mid-operation: immediate return to reset state; sequence restarts from IDLE.
// TESTING
//   Release rst at t=40 ns, clk 25 MHz -> clk100k period 10 us exactly, ms period 1 ms, 50% duty each.
//   npl=2 -> start 1 ms, zero 40 ms, runup 40 ms, repeating with 81 ms period; never two phases high.
//   npl=0 -> zero and runup 20 ms each (treated as npl=1).
//   runup=1, mode=1 -> pwm high 187 clk of every 250, rising aligned to tick100k; mode=0 -> 62 of 250.
//   mode toggled mid-period -> pattern changes only at next tick100k; pwm=0 throughout start/zero.
//   rst pulsed during RUNUP -> all outputs 0 within the same cycle; sequence restarts, START one ms tick later.

Source files
------------

// File: rtl/multislope_timing_core.sv
// Timing core for the multi-slope ADC: reference dividers, 1 ms conversion sequencer and run-up PWM.
// Everything runs on one clock; the dividers produce single-cycle strobes that gate the slower logic.
module multislope_timing_core #(
   parameter int DIV1      = 124,
   parameter int DIV2      = 49,
   parameter int PERIOD    = 249,
   parameter int HI_M1     = 187,
   parameter int HI_M0     = 62,
   parameter int MS_PER_PL = 20
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [9:0] i_npl,
   input  logic       i_mode,
   output logic       o_clk100k,
   output logic       o_ms,
   output logic       o_start,
   output logic       o_zero,
   output logic       o_runup,
   output logic       o_pwm
);

   localparam int W1   = (DIV1 > 0) ? $clog2(DIV1 + 1) : 1;
   localparam int W2   = (DIV2 > 0) ? $clog2(DIV2 + 1) : 1;
   localparam int WP   = (PERIOD > 0) ? $clog2(PERIOD + 1) : 1;
   localparam int WLC  = $clog2(MS_PER_PL * 1023 + 1);
   localparam int WL   = (WLC > 15) ? WLC : 15;

   localparam logic [W1-1:0] C_DIV1 = W1'(DIV1);
   localparam logic [W2-1:0] C_DIV2 = W2'(DIV2);
   localparam logic [WP-1:0] C_PER  = WP'(PERIOD);
   localparam logic [WP-1:0] C_HI1  = WP'(HI_M1);
   localparam logic [WP-1:0] C_HI0  = WP'(HI_M0);

   typedef enum logic [1:0] {IDLE, START, ZERO, RUNUP} state_t;

   logic [W1-1:0] r_cnt1;
   logic          r_clk100k;
   logic [W2-1:0] r_cnt2;
   logic          r_ms;
   state_t        r_state;
   logic [WL-1:0] r_phase;
   logic [WL-1:0] r_len;
   logic          r_start;
   logic          r_zero;
   logic          r_runup;
   logic [WP-1:0] r_pcnt;
   logic          r_modeQ;
   logic          r_pwm;

   logic          w_tick100k;
   logic          w_tick1ms;
   logic [9:0]    w_nplEff;
   logic [WL-1:0] w_len;
   logic          w_phaseLast;
   logic [WP-1:0] w_hi;

   // Strobes fire in the cycle whose closing edge drives the square wave 0->1.
   assign w_tick100k  = (r_cnt1 == C_DIV1) & ~r_clk100k;
   assign w_tick1ms   = w_tick100k & (r_cnt2 == C_DIV2) & ~r_ms;
   assign w_nplEff    = (i_npl == 10'd0) ? 10'd1 : i_npl;
   assign w_len       = WL'(w_nplEff) * WL'(MS_PER_PL);
   assign w_phaseLast = (r_phase == (r_len - 1'b1));
   assign w_hi        = r_modeQ ? C_HI1 : C_HI0;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt1    <= '0;
         r_clk100k <= 1'b0;
      end else if (r_cnt1 == C_DIV1) begin
         r_cnt1    <= '0;
         r_clk100k <= ~r_clk100k;
      end else begin
         r_cnt1    <= r_cnt1 + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt2 <= '0;
         r_ms   <= 1'b0;
      end else if (w_tick100k) begin
         if (r_cnt2 == C_DIV2) begin
            r_cnt2 <= '0;
            r_ms   <= ~r_ms;
         end else begin
            r_cnt2 <= r_cnt2 + 1'b1;
         end
      end
   end

   // Integration length is captured on every entry to START so npl can change between conversions.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_phase <= '0;
         r_len   <= '0;
         r_start <= 1'b0;
         r_zero  <= 1'b0;
         r_runup <= 1'b0;
      end else if (w_tick1ms) begin
         case (r_state)
            IDLE: begin
               r_state <= START;
               r_len   <= w_len;
               r_phase <= '0;
               r_start <= 1'b1;
            end
            START: begin
               r_state <= ZERO;
               r_phase <= '0;
               r_start <= 1'b0;
               r_zero  <= 1'b1;
            end
            ZERO: begin
               if (w_phaseLast) begin
                  r_state <= RUNUP;
                  r_phase <= '0;
                  r_zero  <= 1'b0;
                  r_runup <= 1'b1;
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            RUNUP: begin
               if (w_phaseLast) begin
                  r_state <= START;
                  r_len   <= w_len;
                  r_phase <= '0;
                  r_runup <= 1'b0;
                  r_start <= 1'b1;
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_phase <= '0;
               r_start <= 1'b0;
               r_zero  <= 1'b0;
               r_runup <= 1'b0;
            end
         endcase
      end
   end

   // The 100 kHz strobe re-aligns the PWM counter so each pulse rises in step with the reference.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pcnt  <= '0;
         r_modeQ <= 1'b0;
         r_pwm   <= 1'b0;
      end else begin
         if (w_tick100k) begin
            r_modeQ <= i_mode;
         end
         if (r_start) begin
            r_pcnt <= '0;
            r_pwm  <= 1'b0;
         end else begin
            if (w_tick100k || (r_pcnt == C_PER)) begin
               r_pcnt <= '0;
            end else begin
               r_pcnt <= r_pcnt + 1'b1;
            end
            r_pwm <= r_runup & (r_pcnt < w_hi);
         end
      end
   end

   assign o_clk100k = r_clk100k;
   assign o_ms      = r_ms;
   assign o_start   = r_start;
   assign o_zero    = r_zero;
   assign o_runup   = r_runup;
   assign o_pwm     = r_pwm;

endmodule

// File: tb/tb_multislope_timing_core.sv
// Directed bench: dutA keeps the nominal 25 MHz parameters for divider timing, dutB uses
// shrunken parameters so whole conversion sequences and PWM periods fit in a short run.
module tb_multislope_timing_core;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] nplA = 10'd2;
   logic       modeA = 1'b1;
   logic [9:0] nplB = 10'd2;
   logic       modeB = 1'b1;

   logic clk100kA, msA, startA, zeroA, runupA, pwmA;
   logic clk100kB, msB, startB, zeroB, runupB, pwmB;

   int edgeCnt = 0;
   int nCompared = 0;
   int nMismatched = 0;
   int overlapCnt = 0;
   int pwmInStartZero = 0;
   int pwmAHighs = 0;

   multislope_timing_core dutA (
      .i_clk(clk), .i_rst(rst), .i_npl(nplA), .i_mode(modeA),
      .o_clk100k(clk100kA), .o_ms(msA), .o_start(startA),
      .o_zero(zeroA), .o_runup(runupA), .o_pwm(pwmA)
   );

   multislope_timing_core #(
      .DIV1(4), .DIV2(4), .PERIOD(9), .HI_M1(7), .HI_M0(2), .MS_PER_PL(2)
   ) dutB (
      .i_clk(clk), .i_rst(rst), .i_npl(nplB), .i_mode(modeB),
      .o_clk100k(clk100kB), .o_ms(msB), .o_start(startB),
      .o_zero(zeroB), .o_runup(runupB), .o_pwm(pwmB)
   );

   // 25 MHz clock, first rising edge at 20 ns.
   always #20 clk = ~clk;

   // Edge counter restarts with reset so "edge n" means the n-th rising edge after release.
   always @(posedge clk or posedge rst) begin
      if (rst) edgeCnt <= 0;
      else     edgeCnt <= edgeCnt + 1;
   end

   // Background monitors for properties that must hold on every cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if ((int'(startB) + int'(zeroB) + int'(runupB)) > 1) overlapCnt <= overlapCnt + 1;
         if ((startB | zeroB) & pwmB) pwmInStartZero <= pwmInStartZero + 1;
         if (pwmA) pwmAHighs <= pwmAHighs + 1;
      end
   end

   task automatic applyStimulus(input logic rstVal, input logic [9:0] nplVal, input logic modeVal);
      rst   = rstVal;
      nplB  = nplVal;
      modeB = modeVal;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Returns at the falling edge following rising edge n.
   task automatic waitEdge(input int n);
      while (edgeCnt < n) @(negedge clk);
   endtask

   task automatic countPwmB(input int first, input int last, output int highs);
      highs = 0;
      waitEdge(first);
      for (int e = first; e <= last; e++) begin
         waitEdge(e);
         if (pwmB) highs++;
      end
   endtask

   initial begin
      int highs;

      #30;
      checkOutput("resetA", {26'd0, clk100kA, msA, startA, zeroA, runupA, pwmA}, 32'd0);
      checkOutput("resetB", {26'd0, clk100kB, msB, startB, zeroB, runupB, pwmB}, 32'd0);
      #10;
      applyStimulus(1'b0, 10'd2, 1'b1);
      $display("[TB] reset released");

      waitEdge(4);     checkOutput("B_clk100k_e4", {31'd0, clk100kB}, 32'd0);
      waitEdge(5);     checkOutput("B_clk100k_e5", {31'd0, clk100kB}, 32'd1);
      waitEdge(44);    checkOutput("B_idle_e44", {29'd0, startB, zeroB, runupB}, 32'd0);
      waitEdge(45);    checkOutput("B_start_e45", {28'd0, msB, startB, zeroB, runupB}, 32'b1100);
      waitEdge(124);   checkOutput("A_clk100k_e124", {31'd0, clk100kA}, 32'd0);
      waitEdge(125);   checkOutput("A_clk100k_e125", {31'd0, clk100kA}, 32'd1);
      waitEdge(144);   checkOutput("B_start_e144", {29'd0, startB, zeroB, runupB}, 32'b100);
      waitEdge(145);   checkOutput("B_zero_e145", {29'd0, startB, zeroB, runupB}, 32'b010);
      waitEdge(249);   checkOutput("A_clk100k_e249", {31'd0, clk100kA}, 32'd1);
      waitEdge(250);   checkOutput("A_clk100k_e250", {31'd0, clk100kA}, 32'd0);
      waitEdge(544);   checkOutput("B_zero_e544", {29'd0, startB, zeroB, runupB}, 32'b010);
      waitEdge(545);   checkOutput("B_runup_e545", {29'd0, startB, zeroB, runupB}, 32'b001);
                       checkOutput("B_pwm_e545", {31'd0, pwmB}, 32'd0);
      waitEdge(546);   checkOutput("B_pwm_rise_e546", {31'd0, pwmB}, 32'd1);

      countPwmB(546, 555, highs);
      checkOutput("B_pwm_mode1_highs", highs, 32'd7);

      waitEdge(560);
      applyStimulus(1'b0, 10'd2, 1'b0);
      waitEdge(562);   checkOutput("B_pwm_oldmode_e562", {31'd0, pwmB}, 32'd1);
      waitEdge(563);   checkOutput("B_pwm_oldmode_e563", {31'd0, pwmB}, 32'd0);
      countPwmB(566, 575, highs);
      checkOutput("B_pwm_mode0_highs", highs, 32'd2);

      waitEdge(944);   checkOutput("B_runup_e944", {29'd0, startB, zeroB, runupB}, 32'b001);
      waitEdge(945);   checkOutput("B_restart_e945", {29'd0, startB, zeroB, runupB}, 32'b100);
      waitEdge(12374); checkOutput("A_idle_e12374", {30'd0, msA, startA}, 32'b00);
      waitEdge(12375); checkOutput("A_start_e12375", {30'd0, msA, startA}, 32'b11);
      waitEdge(24874); checkOutput("A_ms_e24874", {31'd0, msA}, 32'd1);
      waitEdge(24875); checkOutput("A_ms_e24875", {31'd0, msA}, 32'd0);
      waitEdge(37374); checkOutput("A_start_e37374", {29'd0, startA, zeroA, runupA}, 32'b100);
      waitEdge(37375); checkOutput("A_zero_e37375", {29'd0, startA, zeroA, runupA}, 32'b010);
      waitEdge(37547); checkOutput("B_runup_pwm_e37547", {28'd0, startB, zeroB, runupB, pwmB}, 32'b0011);
                       checkOutput("A_ms_zero_e37547", {30'd0, msA, zeroA}, 32'b11);

      checkOutput("B_phase_overlap", overlapCnt, 32'd0);
      checkOutput("B_pwm_in_start_zero", pwmInStartZero, 32'd0);
      checkOutput("A_pwm_never_high", pwmAHighs, 32'd0);

      applyStimulus(1'b1, 10'd2, 1'b0);
      #1;
      checkOutput("midrst_A", {26'd0, clk100kA, msA, startA, zeroA, runupA, pwmA}, 32'd0);
      checkOutput("midrst_B", {26'd0, clk100kB, msB, startB, zeroB, runupB, pwmB}, 32'd0);
      repeat (3) @(negedge clk);
      applyStimulus(1'b0, 10'd0, 1'b0);
      $display("[TB] reset released again, npl=0 on dutB");

      waitEdge(44);    checkOutput("B2_idle_e44", {29'd0, startB, zeroB, runupB}, 32'd0);
      waitEdge(45);    checkOutput("B2_start_e45", {29'd0, startB, zeroB, runupB}, 32'b100);
      waitEdge(125);   checkOutput("A2_clk100k_e125", {31'd0, clk100kA}, 32'd1);
      waitEdge(145);   checkOutput("B2_zero_e145", {29'd0, startB, zeroB, runupB}, 32'b010);
      waitEdge(344);   checkOutput("B2_zero_e344", {29'd0, startB, zeroB, runupB}, 32'b010);
      waitEdge(345);   checkOutput("B2_runup_e345", {29'd0, startB, zeroB, runupB}, 32'b001);
      waitEdge(544);   checkOutput("B2_runup_e544", {29'd0, startB, zeroB, runupB}, 32'b001);
      waitEdge(545);   checkOutput("B2_start_e545", {29'd0, startB, zeroB, runupB}, 32'b100);
      checkOutput("B2_phase_overlap", overlapCnt, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
